// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and helpers for the cache memory-side logic
package cache_pkg;

    // Line-to-word adapter sequencing.
    typedef enum logic [1:0] {
        AdIdle,
        AdRead,
        AdWrite,
        AdDone
    } cache_adapter_state_t;

    // Number of bus words making up one cache line.
    function automatic int cache_beats(input int line, input int bus);
        return line / bus;
    endfunction

endpackage

// File: rtl/cache_bus_adapter.sv
// rtl/cache_bus_adapter.sv - serialises one cache line request into bus word beats
//
// Ports:
//   clock, reset          : clock, asynchronous active-low reset
//   cache_rd_en/wr_en     : line read / write-back request, held until cache_ack
//   cache_addr            : line byte address (line offset bits ignored)
//   cache_sel             : per-byte write enables for the line
//   cache_wr_line         : line to write
//   cache_rd_line         : assembled read line, valid while cache_ack
//   cache_ack             : one-cycle line completion pulse
//   bus_rd_en/bus_wr_en   : word read / write strobes
//   bus_addr              : word byte address
//   bus_wr_data, bus_sel  : write word and its byte enables
//   bus_rd_data, bus_ack  : read word and beat completion from memory
module cache_bus_adapter
    import cache_pkg::*;
#(
    parameter int LINE_WIDTH = 128,
    parameter int BUS_WIDTH  = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cache_rd_en,
    input  logic                    cache_wr_en,
    input  logic [ADDR_WIDTH-1:0]   cache_addr,
    input  logic [LINE_WIDTH/8-1:0] cache_sel,
    input  logic [LINE_WIDTH-1:0]   cache_wr_line,
    output logic [LINE_WIDTH-1:0]   cache_rd_line,
    output logic                    cache_ack,
    output logic                    bus_rd_en,
    output logic                    bus_wr_en,
    output logic [ADDR_WIDTH-1:0]   bus_addr,
    output logic [BUS_WIDTH-1:0]    bus_wr_data,
    output logic [BUS_WIDTH/8-1:0]  bus_sel,
    input  logic [BUS_WIDTH-1:0]    bus_rd_data,
    input  logic                    bus_ack
);

    localparam int BEATS      = cache_beats(LINE_WIDTH, BUS_WIDTH);
    localparam int CW         = $clog2(BEATS);
    localparam int BSEL_W     = BUS_WIDTH / 8;
    localparam int WORD_SHIFT = $clog2(BSEL_W);
    localparam logic [CW-1:0]         LAST_BEAT = CW'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_WIDTH / 8 - 1);

    cache_adapter_state_t    state_q, state_d;
    logic [CW-1:0]           beat_q, beat_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [LINE_WIDTH-1:0]   wr_line_q, wr_line_d;
    logic [LINE_WIDTH/8-1:0] sel_q, sel_d;
    logic [LINE_WIDTH-1:0]   rd_line_q, rd_line_d;
    // Set for the Idle cycle right after Done, while the cache may still be
    // holding the request it just had acknowledged.
    logic                    rearm_q;

    logic [BSEL_W-1:0]       cur_sel;
    logic [ADDR_WIDTH-1:0]   beat_addr;
    logic                    last_beat;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= AdIdle;
            beat_q    <= '0;
            base_q    <= '0;
            wr_line_q <= '0;
            sel_q     <= '0;
            rd_line_q <= '0;
            rearm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            base_q    <= base_d;
            wr_line_q <= wr_line_d;
            sel_q     <= sel_d;
            rd_line_q <= rd_line_d;
            rearm_q   <= (state_q == AdDone);
        end
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        base_d    = base_q;
        wr_line_d = wr_line_q;
        sel_d     = sel_q;
        rd_line_d = rd_line_q;

        cache_ack   = 1'b0;
        bus_rd_en   = 1'b0;
        bus_wr_en   = 1'b0;
        bus_addr    = '0;
        bus_wr_data = '0;
        bus_sel     = '0;

        cur_sel   = sel_q[int'(beat_q) * BSEL_W +: BSEL_W];
        beat_addr = base_q + (ADDR_WIDTH'(beat_q) << WORD_SHIFT);
        last_beat = (beat_q == LAST_BEAT);

        case (state_q)
            AdIdle: begin
                if (!rearm_q) begin
                    if (cache_wr_en) begin
                        base_d    = cache_addr & LINE_MASK;
                        wr_line_d = cache_wr_line;
                        sel_d     = cache_sel;
                        beat_d    = '0;
                        state_d   = AdWrite;
                    end else if (cache_rd_en) begin
                        base_d  = cache_addr & LINE_MASK;
                        beat_d  = '0;
                        state_d = AdRead;
                    end
                end
            end

            AdRead: begin
                bus_rd_en = 1'b1;
                bus_sel   = '1;
                bus_addr  = beat_addr;
                if (bus_ack) begin
                    rd_line_d[int'(beat_q) * BUS_WIDTH +: BUS_WIDTH] = bus_rd_data;
                    if (last_beat) begin
                        state_d = AdDone;
                    end else begin
                        beat_d = beat_q + CW'(1);
                    end
                end
            end

            AdWrite: begin
                // A beat with no enabled bytes never reaches the bus.
                if (cur_sel == '0 || bus_ack) begin
                    if (last_beat) begin
                        state_d = AdDone;
                    end else begin
                        beat_d = beat_q + CW'(1);
                    end
                end
                if (cur_sel != '0) begin
                    bus_wr_en   = 1'b1;
                    bus_addr    = beat_addr;
                    bus_wr_data = wr_line_q[int'(beat_q) * BUS_WIDTH +: BUS_WIDTH];
                    bus_sel     = cur_sel;
                end
            end

            AdDone: begin
                cache_ack = 1'b1;
                state_d   = AdIdle;
            end

            default: state_d = AdIdle;
        endcase
    end

    assign cache_rd_line = rd_line_q;

endmodule

// File: tb/tb_cache_bus_adapter.sv
// tb/tb_cache_bus_adapter.sv - randomized model-checked bench for cache_bus_adapter
module tb_cache_bus_adapter;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         cache_rd_en, cache_wr_en;
    logic [31:0]  cache_addr;
    logic [15:0]  cache_sel;
    logic [127:0] cache_wr_line;
    logic [127:0] cache_rd_line;
    logic         cache_ack;
    logic         bus_rd_en, bus_wr_en;
    logic [31:0]  bus_addr;
    logic [31:0]  bus_wr_data;
    logic [3:0]   bus_sel;
    logic [31:0]  bus_rd_data;
    logic         bus_ack;

    cache_bus_adapter #(.LINE_WIDTH(128), .BUS_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clock(clock), .reset(reset),
        .cache_rd_en(cache_rd_en), .cache_wr_en(cache_wr_en),
        .cache_addr(cache_addr), .cache_sel(cache_sel),
        .cache_wr_line(cache_wr_line), .cache_rd_line(cache_rd_line),
        .cache_ack(cache_ack),
        .bus_rd_en(bus_rd_en), .bus_wr_en(bus_wr_en), .bus_addr(bus_addr),
        .bus_wr_data(bus_wr_data), .bus_sel(bus_sel),
        .bus_rd_data(bus_rd_data), .bus_ack(bus_ack)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        int          wt;
    } beat_t;

    beat_t        exp_q[$];
    logic [31:0]  addr_log[$];
    logic [3:0]   sel_log[$];
    bit           pending = 0;
    bit           exp_rd = 0;
    logic [127:0] exp_line;
    int           exp_ack_cyc = 0;
    int           last_ack_cyc = 0;
    int           ack_cnt = 0;
    logic [127:0] last_rd_line;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Bus responder plus the per-cycle comparison against the expected beat list.
    always @(negedge clock) begin
        if (!reset) begin
            bus_ack = 1'b0;
        end else begin
            if (bus_rd_en && bus_wr_en) chk("dual_strobe", 1'b1, 1'b0);
            if (bus_rd_en || bus_wr_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", {bus_wr_en, bus_rd_en}, 2'b00);
                    bus_ack = 1'b0;
                end else begin
                    chk("beat_kind", bus_wr_en, exp_q[0].wr);
                    chk("beat_addr", bus_addr, exp_q[0].addr);
                    chk("beat_sel", bus_sel, exp_q[0].sel);
                    if (exp_q[0].wr) chk("beat_wdata", bus_wr_data, exp_q[0].data);
                    if (exp_q[0].wt == 0) begin
                        bus_ack     = 1'b1;
                        bus_rd_data = exp_q[0].data;
                        addr_log.push_back(bus_addr);
                        sel_log.push_back(bus_sel);
                        void'(exp_q.pop_front());
                    end else begin
                        exp_q[0].wt = exp_q[0].wt - 1;
                        bus_ack     = 1'b0;
                        bus_rd_data = $urandom;
                    end
                end
            end else begin
                // Stray acks with no strobe must have no effect.
                bus_ack     = 1'($urandom_range(0, 1));
                bus_rd_data = $urandom;
            end

            if (cache_ack) begin
                if (!pending) begin
                    chk("spurious_ack", cache_ack, 1'b0);
                end else begin
                    chk("ack_cycle", cyc, exp_ack_cyc);
                    chk("beats_left_at_ack", exp_q.size(), 0);
                    if (exp_rd) chk("rd_line", cache_rd_line, exp_line);
                end
                pending      = 0;
                last_ack_cyc = cyc;
                last_rd_line = cache_rd_line;
                ack_cnt++;
            end else if (pending && cyc == exp_ack_cyc) begin
                chk("ack_missing", cache_ack, 1'b1);
            end
        end
    end

    // One line transaction: builds the expected beat list from the request,
    // holds the request until one cycle past the ack, then drops it.
    task automatic txn(input bit wr, input bit both, input logic [31:0] addr,
                       input logic [127:0] line, input logic [15:0] sel,
                       input int wfix, output int lat);
        logic [31:0] base;
        int tot, w, a0, n, rq;
        @(posedge clock); #1;
        base = {addr[31:4], 4'h0};
        tot  = 1;
        for (int i = 0; i < 4; i++) begin
            beat_t b;
            w = (wfix < 0) ? int'($urandom_range(0, 3)) : wfix;
            b.wr   = wr;
            b.addr = base + 32'(4 * i);
            b.data = line[32 * i +: 32];
            b.sel  = wr ? sel[4 * i +: 4] : 4'hF;
            b.wt   = w;
            if (b.sel != 4'h0) begin
                exp_q.push_back(b);
                tot += 1 + w;
            end else begin
                tot += 1;
            end
        end
        rq          = cyc;
        exp_ack_cyc = cyc + tot;
        exp_rd      = !wr;
        exp_line    = line;
        pending     = 1;
        a0          = ack_cnt;
        cache_wr_en   = wr;
        cache_rd_en   = !wr || both;
        cache_addr    = addr;
        cache_sel     = wr ? sel : 16'($urandom);
        cache_wr_line = wr ? line : {$urandom, $urandom, $urandom, $urandom};
        // Request has been sampled; scramble the payload while still requesting.
        @(posedge clock); #1;
        cache_addr    = $urandom;
        cache_sel     = 16'($urandom);
        cache_wr_line = {$urandom, $urandom, $urandom, $urandom};
        n = 0;
        while (ack_cnt == a0 && n < 300) begin
            @(posedge clock); #1;
            n++;
        end
        if (ack_cnt == a0) begin
            chk("ack_timeout", 1'b0, 1'b1);
            exp_q.delete();
            pending = 0;
            lat = -1;
        end else begin
            lat = last_ack_cyc - rq;
        end
        // Cycle right after the ack: request still up and must not be taken.
        @(posedge clock); #1;
        cache_rd_en = 1'b0;
        cache_wr_en = 1'b0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_rd_line"}, cache_rd_line, 128'h0);
        chk({tag, "_cache_ack"}, cache_ack, 1'b0);
        chk({tag, "_strobes"}, {bus_rd_en, bus_wr_en}, 2'b00);
        chk({tag, "_bus_addr"}, bus_addr, 32'h0);
        chk({tag, "_bus_wdata"}, bus_wr_data, 32'h0);
        chk({tag, "_bus_sel"}, bus_sel, 4'h0);
    endtask

    int lat;
    logic [127:0] rline;
    logic [15:0]  rsel;

    initial begin
        cache_rd_en = 0; cache_wr_en = 0; cache_addr = 0; cache_sel = 0;
        cache_wr_line = 0; bus_ack = 0; bus_rd_data = 0;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk_zero_outputs("reset");
        reset = 1'b1;

        // Zero-wait read.
        addr_log.delete();
        txn(0, 0, 32'h1004, 128'h44444444_33333333_22222222_11111111, 16'h0, 0, lat);
        chk("zw_latency", lat, 5);
        chk("zw_beats", addr_log.size(), 4);
        if (addr_log.size() == 4) begin
            chk("zw_addr0", addr_log[0], 32'h1000);
            chk("zw_addr1", addr_log[1], 32'h1004);
            chk("zw_addr2", addr_log[2], 32'h1008);
            chk("zw_addr3", addr_log[3], 32'h100C);
        end
        chk("zw_line", last_rd_line, 128'h44444444_33333333_22222222_11111111);

        // Three wait cycles on every beat.
        txn(0, 0, 32'h1004, {$urandom, $urandom, $urandom, $urandom}, 16'h0, 3, lat);
        chk("ws_latency", lat, 17);

        // Full write.
        addr_log.delete(); sel_log.delete();
        txn(1, 0, 32'h2010, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 16'hFFFF, -1, lat);
        chk("full_beats", addr_log.size(), 4);
        if (sel_log.size() == 4) chk("full_sel3", sel_log[3], 4'hF);

        // Sparse write: only word 2 enabled.
        addr_log.delete(); sel_log.delete();
        txn(1, 0, 32'h1000, {$urandom, $urandom, $urandom, $urandom}, 16'h0F00, 0, lat);
        chk("sparse_beats", addr_log.size(), 1);
        if (addr_log.size() == 1) begin
            chk("sparse_addr", addr_log[0], 32'h1008);
            chk("sparse_sel", sel_log[0], 4'hF);
        end
        chk("sparse_latency", lat, 5);

        // Empty write.
        addr_log.delete();
        txn(1, 0, 32'h3000, {$urandom, $urandom, $urandom, $urandom}, 16'h0000, -1, lat);
        chk("empty_beats", addr_log.size(), 0);
        chk("empty_latency", lat, 5);

        // Both requests together: the write goes out.
        txn(1, 1, 32'h5020, {$urandom, $urandom, $urandom, $urandom}, 16'hF0F0, -1, lat);

        // Reset in the middle of a read.
        @(posedge clock); #1;
        exp_q.delete(); addr_log.delete();
        for (int i = 0; i < 4; i++) begin
            beat_t b;
            b.wr = 0; b.addr = 32'h4000 + 32'(4 * i); b.data = $urandom; b.sel = 4'hF; b.wt = 1;
            exp_q.push_back(b);
        end
        cache_rd_en = 1'b1;
        cache_addr  = 32'h4000;
        for (int n = 0; n < 100 && addr_log.size() < 2; n++) begin
            @(posedge clock); #1;
        end
        chk("rst_beats_before", addr_log.size(), 2);
        reset = 1'b0;
        #1;
        chk_zero_outputs("midrst");
        exp_q.delete();
        cache_rd_en = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        addr_log.delete();
        txn(0, 0, 32'h4000, {$urandom, $urandom, $urandom, $urandom}, 16'h0, 0, lat);
        if (addr_log.size() > 0) chk("restart_addr0", addr_log[0], 32'h4000);
        chk("restart_latency", lat, 5);

        // Random traffic.
        for (int t = 0; t < 40; t++) begin
            rline = {$urandom, $urandom, $urandom, $urandom};
            for (int k = 0; k < 4; k++) begin
                case ($urandom_range(0, 3))
                    0:       rsel[4 * k +: 4] = 4'h0;
                    1:       rsel[4 * k +: 4] = 4'hF;
                    default: rsel[4 * k +: 4] = 4'($urandom);
                endcase
            end
            txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, rline, rsel, -1, lat);
        end

        repeat (4) @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
